tick_debouncer: RTL and testbench
=================================

Name: tick_debouncer

Overview:
- Downstream consumer of the 16-bit up-counter's `ovf` strobe, which is used here as the sample tick.
- Debounces one asynchronous input (button or switch) in units of ticks. The input is first synchronised, then must differ from the current output for `STABLE_TICKS` consecutive ticks before the output changes.
- Emits the clean level plus one-cycle rise/fall pulses to control logic.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on `din`; legal range 2..4.
- STABLE_TICKS, 4, consecutive qualifying ticks required to commit a new level; minimum 1.
- CNT_W, clog2(STABLE_TICKS+1), width of the tick counter; derived, not overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous and active-high (one clock; reset is asynchronous and active-high).
- tick  in  1  sample strobe, one-cycle pulses; normally driven by the counter's `ovf`.
- din  in  1  raw asynchronous input.
- dout  out  1  debounced level, registered.
- rise  out  1  one-cycle pulse on the cycle `dout` becomes 1.
- fall  out  1  one-cycle pulse on the cycle `dout` becomes 0.
- busy  out  1  high while a candidate change is being qualified (state CHECK).

Behaviour:
- Reset (async assert, sync deassert by the environment):
  - synchroniser flops = 0, `dout` = 0, `rise` = 0, `fall` = 0, `busy` = 0.
  - cnt = 0, state = IDLE.
  - Reset mid-qualification aborts it with no pulse.
- Synchroniser: `s` is `din` delayed by SYNC_STAGES clk edges. No other logic sees `din`.
- Mismatch: `m = (s != dout)`. A qualifying tick is `tick && m`.
- FSM states: IDLE, CHECK.
- IDLE:
  - `m == 0`: stay in IDLE, cnt = 0.
  - `m == 1` and no tick: go to CHECK, cnt = 0.
  - `m == 1` with tick and STABLE_TICKS == 1: commit (see below), stay in IDLE.
  - `m == 1` with tick and STABLE_TICKS > 1: go to CHECK, cnt = 1.
- CHECK:
  - `m == 0` on any cycle, tick or not: go to IDLE, cnt = 0, no commit. This check has priority over a coincident tick.
  - Qualifying tick with cnt == STABLE_TICKS-1: commit, go to IDLE, cnt = 0.
  - Qualifying tick otherwise: cnt = cnt + 1.
  - No tick: hold.
- Commit, at a single clk edge:
  - `dout <= ~dout`.
  - `rise <= ~dout`, `fall <= dout` (values before the toggle).
  - The pulse is visible in the same cycle as the new `dout` level and lasts exactly one cycle.
- Pulse clearing: `rise` and `fall` are 0 on every non-commit cycle. They are never both 1.
- `busy` is registered: `busy = (state == CHECK)`.
- Counter arithmetic: cnt is an unsigned CNT_W-bit value. It never exceeds STABLE_TICKS-1 and never wraps.
- `tick` held high continuously: every cycle is a tick, so the block degenerates to a cycle-count debouncer. This is legal.
- Latency from a `din` edge to `dout`: SYNC_STAGES cycles, then STABLE_TICKS qualifying ticks, with `dout` updating at the edge of the last qualifying tick.
- The output does not react to `din` changes shorter than STABLE_TICKS tick periods.

Decomposition:
- Shared package `debounce_pkg` holds:
  - state enum (IDLE = 0, CHECK = 1);
  - a clog2 constant function;
  - a default-period constant, TICK_PERIOD = 26 cycles, matching the counter's compare value 25.
- One sub-module, `sync_ff`:
  - parameterised SYNC_STAGES-deep synchroniser;
  - async reset to 0;
  - reused by other input blocks.
- FSM, counter and output registers stay in `tick_debouncer`.

Test Plan:
All scenarios use STABLE_TICKS=4, SYNC_STAGES=2 and a tick every 26 clk unless stated.
1. Clean press: `din` 0->1 held.
   -> `busy` rises 3 cycles after the edge.
   -> `dout` = 1 and `rise` = 1 for exactly 1 cycle at the 4th tick after `s` = 1; `fall` stays 0.
2. Bounce: `din` high across 3 ticks, then low before the 4th.
   -> `dout` stays 0, no pulses, `busy` returns to 0 within 3 cycles of `din` falling.
3. Release: from `dout` = 1, `din` 1->0 held for 5 ticks.
   -> `fall` pulses once at the 4th qualifying tick, `dout` = 0.
4. Continuous tick (`tick` = 1 every cycle): `din` rises.
   -> `dout` = 1 at the 6th clk edge after the `din` edge (2 sync + 4 ticks).
5. Reset in CHECK with cnt = 3: assert `rst` for 2 cycles mid-period.
   -> `dout`/`rise`/`fall`/`busy` = 0 immediately (asynchronously).
   -> After release with `din` still high, a full 4 fresh ticks are needed before `dout` = 1.
6. Edge cases:
   -> STABLE_TICKS=1: `dout` follows `s` on the first tick, with no CHECK cycle when the tick coincides with the mismatch.
   -> `s` returning equal to `dout` on a tick cycle: no commit, cnt cleared.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for tick-based input debouncers: FSM state encoding,
// a constant clog2 helper and the default tick period of the upstream counter.
package debounce_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_t;

  // Upstream 16-bit counter compares against 25, so it strobes every 26 clocks.
  localparam int TICK_PERIOD = 26;

  // Ceiling log2 for sizing counters; never returns less than 1 bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous input. The output is the
// input delayed by STAGES clock edges; all flops clear on reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sh;

  // Shift the raw input through the synchroniser chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh <= '0;
    end else begin
      r_sh <= {r_sh[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sh[STAGES-1];

endmodule

// File: rtl/tick_debouncer.sv
// Debounces one asynchronous input using an external sample tick. A new level
// is committed only after the synchronised input has differed from the output
// for STABLE_TICKS consecutive ticks; rise/fall pulse on the commit cycle.
module tick_debouncer
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int               CNT_W    = clog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             w_s;
  logic             w_m;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dout;
  logic             r_rise;
  logic             r_fall;
  logic             r_busy;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .i_d(din),
    .o_q(w_s)
  );

  // A mismatch means the synchronised input disagrees with the committed level.
  assign w_m = w_s ^ r_dout;

  // Qualification FSM with tick counter and registered level/pulse/busy outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dout  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_m) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
          end else if (tick && (STABLE_TICKS == 1)) begin
            // Single-tick qualification commits straight from IDLE.
            r_dout <= ~r_dout;
            r_rise <= ~r_dout;
            r_fall <= r_dout;
            r_cnt  <= '0;
            r_busy <= 1'b0;
          end else begin
            r_state <= CHECK;
            r_busy  <= 1'b1;
            r_cnt   <= tick ? CNT_ONE : '0;
          end
        end
        CHECK: begin
          if (!w_m) begin
            // Input fell back to the current level: abandon, even on a tick.
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (tick) begin
            if (r_cnt == CNT_LAST) begin
              r_dout  <= ~r_dout;
              r_rise  <= ~r_dout;
              r_fall  <= r_dout;
              r_state <= IDLE;
              r_cnt   <= '0;
              r_busy  <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end else begin
            r_cnt <= r_cnt;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dout = r_dout;
  assign rise = r_rise;
  assign fall = r_fall;
  assign busy = r_busy;

endmodule

// File: tb/tb_tick_debouncer.sv
// Randomised scoreboard bench for tick_debouncer. Two instances share stimulus:
// STABLE_TICKS=4 and STABLE_TICKS=1, both with a 2-flop synchroniser.
module tb_tick_debouncer;
  import debounce_pkg::*;

  localparam int ST_A = 4;
  localparam int ST_B = 1;

  logic clk = 1'b0;
  logic rst;
  logic tick;
  logic din;
  logic dout_a, rise_a, fall_a, busy_a;
  logic dout_b, rise_b, fall_b, busy_b;

  int n_checks = 0;
  int n_pass   = 0;
  int tcnt     = 0;

  logic [3:0] q_a[$];
  logic [3:0] q_b[$];

  // Reference model state: committed level, ticks seen during the current
  // uninterrupted mismatch run, and whether a candidate is being qualified.
  bit m_dout[2];
  bit m_busy[2];
  int m_ticks[2];
  int m_st[2];
  bit hist[$];

  tick_debouncer #(.SYNC_STAGES(2), .STABLE_TICKS(ST_A)) u_dut_a (
    .clk(clk), .rst(rst), .tick(tick), .din(din),
    .dout(dout_a), .rise(rise_a), .fall(fall_a), .busy(busy_a)
  );

  tick_debouncer #(.SYNC_STAGES(2), .STABLE_TICKS(ST_B)) u_dut_b (
    .clk(clk), .rst(rst), .tick(tick), .din(din),
    .dout(dout_b), .rise(rise_b), .fall(fall_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s actual{dout,rise,fall,busy}=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_dout[i]  = 1'b0;
      m_busy[i]  = 1'b0;
      m_ticks[i] = 0;
    end
    hist.delete();
    hist.push_back(1'b0);
    hist.push_back(1'b0);
  endfunction

  // One clock edge of the behavioural rule: the level flips once the input has
  // disagreed continuously for m_st ticks; any agreement restarts the run.
  function automatic logic [3:0] model_step(input int i, input bit s, input bit t);
    bit r;
    bit f;
    r = 1'b0;
    f = 1'b0;
    if (s == m_dout[i]) begin
      m_ticks[i] = 0;
      m_busy[i]  = 1'b0;
    end else begin
      if (t) m_ticks[i] = m_ticks[i] + 1;
      if (m_ticks[i] >= m_st[i]) begin
        r          = !m_dout[i];
        f          = m_dout[i];
        m_dout[i]  = !m_dout[i];
        m_ticks[i] = 0;
        m_busy[i]  = 1'b0;
      end else begin
        m_busy[i] = 1'b1;
      end
    end
    return {m_dout[i], r, f, m_busy[i]};
  endfunction

  // Model advances on every clock edge (or resets) and queues expected outputs.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
      q_a.delete();
      q_b.delete();
      q_a.push_back(4'b0000);
      q_b.push_back(4'b0000);
    end else begin
      bit s_v;
      s_v = hist.pop_front();
      hist.push_back(din);
      q_a.push_back(model_step(0, s_v, tick));
      q_b.push_back(model_step(1, s_v, tick));
    end
  end

  // Monitor pops one expectation per instance and compares on the falling edge.
  always @(negedge clk) begin
    if (q_a.size() > 0) check("st4_out", {dout_a, rise_a, fall_a, busy_a}, q_a.pop_front());
    if (q_b.size() > 0) check("st1_out", {dout_b, rise_b, fall_b, busy_b}, q_b.pop_front());
  end

  // mode 0: periodic tick, 1: tick every cycle, 2: random tick.
  task automatic run_phase(input int ncyc, input int mode, input int hmin, input int hmax);
    int hold;
    hold = $urandom_range(hmax, hmin);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #2;
      case (mode)
        0: tick = (tcnt == TICK_PERIOD - 1);
        1: tick = 1'b1;
        default: tick = ($urandom_range(3, 0) == 0);
      endcase
      tcnt = (tcnt == TICK_PERIOD - 1) ? 0 : tcnt + 1;
      if (hold == 0) begin
        din  = ~din;
        hold = $urandom_range(hmax, hmin);
      end else begin
        hold--;
      end
    end
  endtask

  initial begin
    m_st[0] = ST_A;
    m_st[1] = ST_B;
    rst  = 1'b1;
    tick = 1'b0;
    din  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;

    // Presses, bounces and releases with the standard tick period.
    run_phase(3000, 0, 10, 160);
    // Continuous tick: short glitches versus cycle-count qualification.
    run_phase(1500, 1, 1, 12);
    // Irregular tick spacing.
    run_phase(1500, 2, 2, 40);

    // Settle low, then press and reset while the 4-tick instance is at cnt=3.
    din = 1'b0;
    run_phase(200, 0, 100000, 100000);
    din = 1'b1;
    for (int k = 0; k < 300 && !(m_ticks[0] == 3 && m_busy[0]); k++) begin
      run_phase(1, 0, 100000, 100000);
    end
    if (!(m_ticks[0] == 3 && m_busy[0])) begin
      n_checks++;
      $display("FAIL reach_cnt3 actual ticks=%0d required=3", m_ticks[0]);
    end
    run_phase(5, 0, 100000, 100000);
    @(posedge clk);
    #2;
    tick = 1'b0;
    rst  = 1'b1;
    #1;
    check("async_rst_a", {dout_a, rise_a, fall_a, busy_a}, 4'b0000);
    check("async_rst_b", {dout_b, rise_b, fall_b, busy_b}, 4'b0000);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    // din still high: a fresh full qualification is required after reset.
    run_phase(300, 0, 100000, 100000);

    // Final mixed random traffic.
    run_phase(2000, 0, 5, 140);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
